// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch digit counters.
// Holds the run-state encoding and count direction constants.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/modn_step.sv
// Mod-N next-value and terminal-count logic for one digit.
// Purely combinational; wraps at 0 and MODULUS-1.
module modn_step
  import stopwatch_pkg::*;
#(
  parameter int MODULUS = 6,
  parameter int WIDTH   = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic             dir,
  output logic [WIDTH-1:0] next_value,
  output logic             at_terminal
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_comb begin
    at_terminal = 1'b0;
    next_value  = value;
    if (dir == DIR_DOWN) begin
      at_terminal = (value == '0);
      next_value  = at_terminal ? TOP : value - ONE;
    end else begin
      at_terminal = (value == TOP);
      next_value  = at_terminal ? '0 : value + ONE;
    end
  end

endmodule

// File: rtl/modn_digit_counter.sv
// One stopwatch digit: mod-N up/down counter with run/pause control.
// cout is combinational so a chained digit advances on the same edge.
module modn_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int MODULUS = 6,
  parameter int WIDTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_resume,
  input  logic             stop,
  input  logic             clear,
  input  logic             cin,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] number,
  output logic             cout,
  output logic             running
);

  if (WIDTH < 1 || WIDTH > 8) begin : g_bad_width
    $error("modn_digit_counter: WIDTH out of range 1..8");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_mod
    $error("modn_digit_counter: MODULUS out of range 2..2**WIDTH");
  end

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] number_nx;
  logic [WIDTH-1:0] step_value;
  logic [WIDTH-1:0] sat_value;
  logic             at_terminal;
  logic             count_en;

  modn_step #(
    .MODULUS(MODULUS),
    .WIDTH  (WIDTH)
  ) u_step (
    .value      (number),
    .dir        (dir),
    .next_value (step_value),
    .at_terminal(at_terminal)
  );

  assign sat_value = ({1'b0, load_value} >= MOD_EXT) ? TOP : load_value;
  assign count_en  = (state == RUN) & cin & ~clear & ~load & ~stop;
  assign cout      = count_en & at_terminal;

  always_comb begin
    state_nx  = state;
    number_nx = number;
    priority case (1'b1)
      clear: begin
        state_nx  = IDLE;
        number_nx = '0;
      end
      load: number_nx = sat_value;
      stop: begin
        if (state == RUN) state_nx = PAUSED;
      end
      (start_resume && state != RUN): state_nx = RUN;
      count_en: number_nx = step_value;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      number  <= '0;
      running <= 1'b0;
    end else begin
      state   <= state_nx;
      number  <= number_nx;
      running <= (state_nx == RUN);
    end
  end

endmodule

// File: tb/tb_modn_digit_counter.sv
// Scoreboard bench: mod-6 digit, chained 10x6 pair and mod-2 digit.
// Expected values come from an arithmetic model of the counting rules.
module tb_modn_digit_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_resume = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       cin = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic       lv2 = 1'b0;

  logic [3:0] number, lo_num, hi_num;
  logic       cout, running;
  logic       lo_cout, lo_run, hi_cout, hi_run;
  logic [0:0] n2;
  logic       co2, run2;

  always #5 clk = ~clk;

  modn_digit_counter #(.MODULUS(6), .WIDTH(4)) u_dut (
    .clk(clk), .reset(reset), .start_resume(start_resume),
    .stop(stop), .clear(clear), .cin(cin), .dir(dir),
    .load(load), .load_value(load_value),
    .number(number), .cout(cout), .running(running));

  modn_digit_counter #(.MODULUS(10), .WIDTH(4)) u_lo (
    .clk(clk), .reset(reset), .start_resume(start_resume),
    .stop(stop), .clear(clear), .cin(cin), .dir(dir),
    .load(1'b0), .load_value(4'd0),
    .number(lo_num), .cout(lo_cout), .running(lo_run));

  modn_digit_counter #(.MODULUS(6), .WIDTH(4)) u_hi (
    .clk(clk), .reset(reset), .start_resume(start_resume),
    .stop(stop), .clear(clear), .cin(lo_cout), .dir(dir),
    .load(1'b0), .load_value(4'd0),
    .number(hi_num), .cout(hi_cout), .running(hi_run));

  modn_digit_counter #(.MODULUS(2), .WIDTH(1)) u_m2 (
    .clk(clk), .reset(reset), .start_resume(start_resume),
    .stop(stop), .clear(clear), .cin(cin), .dir(dir),
    .load(load), .load_value(lv2),
    .number(n2), .cout(co2), .running(run2));

  typedef struct {
    int num; int run; int co;
    int lo; int lco; int hi; int hco;
    int n2; int co2;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // model: state 0=idle 1=run 2=paused
  int m_st, m_num, l_st, l_num, h_st, h_num, t_st, t_num;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_num = 0; l_st = 0; l_num = 0;
    h_st = 0; h_num = 0; t_st = 0; t_num = 0;
  endtask

  task automatic step(input int m, inout int st, inout int num,
                      input bit s, p, c, l, input int lv,
                      input bit ci, dr, output bit co);
    co = 1'b0;
    if (c) begin
      num = 0; st = 0;
    end else if (l) begin
      num = (lv >= m) ? m - 1 : lv;
    end else if (p) begin
      if (st == 1) st = 2;
    end else if (st == 1) begin
      if (ci) begin
        if (!dr) begin
          co = (num == m - 1); num = (num + 1) % m;
        end else begin
          co = (num == 0); num = (num + m - 1) % m;
        end
      end
    end else if (s) begin
      st = 1;
    end
  endtask

  task automatic drive(input bit s, p, c, l, input int lv,
                       input bit ci, dr);
    exp_t e;
    bit co, lco, hco, c2;
    @(posedge clk);
    #1;
    start_resume = s; stop = p; clear = c; load = l;
    load_value = 4'(lv); lv2 = 1'(lv & 1);
    cin = ci; dir = dr;
    e.num = m_num; e.run = (m_st == 1) ? 1 : 0;
    e.lo = l_num; e.hi = h_num; e.n2 = t_num;
    step(6, m_st, m_num, s, p, c, l, lv, ci, dr, co);
    step(10, l_st, l_num, s, p, c, 1'b0, 0, ci, dr, lco);
    step(6, h_st, h_num, s, p, c, 1'b0, 0, lco, dr, hco);
    step(2, t_st, t_num, s, p, c, l, lv & 1, ci, dr, c2);
    e.co = co; e.lco = lco; e.hco = hco; e.co2 = c2;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("number", int'(number), e.num);
        chk("running", int'(running), e.run);
        chk("cout", int'(cout), e.co);
        chk("lo_number", int'(lo_num), e.lo);
        chk("lo_cout", int'(lo_cout), e.lco);
        chk("hi_number", int'(hi_num), e.hi);
        chk("hi_cout", int'(hi_cout), e.hco);
        chk("m2_number", int'(n2), e.n2);
        chk("m2_cout", int'(co2), e.co2);
      end
    end
  end

  initial begin : stim
    int waitc;
    model_reset();
    cin = 1'b1;
    #12;
    chk("rst_number", int'(number), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_cout", int'(cout), 0);
    #8 reset = 1'b1;

    drive(1, 0, 0, 0, 0, 1, 0);
    repeat (8) drive(0, 0, 0, 0, 0, 1, 0);
    repeat (8) drive(0, 0, 0, 0, 0, 1, 1);

    drive(0, 0, 1, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 0, 1, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 1, 0);

    drive(0, 0, 0, 1, 9, 1, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 1, 9, 1, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 1, 0);

    drive(1, 0, 0, 0, 0, 1, 0);
    repeat (73) drive(0, 0, 0, 0, 0, 1, 0);
    #6 reset = 1'b0;
    #1;
    chk("async_number", int'(number), 0);
    chk("async_running", int'(running), 0);
    chk("async_lo", int'(lo_num), 0);
    chk("async_hi", int'(hi_num), 0);
    chk("async_m2", int'(n2), 0);
    #1 reset = 1'b1;
    model_reset();

    repeat (1500) begin
      drive(($urandom % 4) == 0, ($urandom % 10) == 0,
            ($urandom % 40) == 0, ($urandom % 12) == 0,
            int'($urandom_range(0, 15)),
            ($urandom % 4) != 0, ($urandom % 3) == 0);
    end

    waitc = 0;
    while (sb.size() > 0 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modn_digit_counter.md
MODN_DIGIT_COUNTER -- requirements
Module: modn_digit_counter

Interface
REQ-001 Parameter MODULUS, default 6: count modulus; legal range 2..2**WIDTH.
REQ-002 Parameter WIDTH, default 4: width of number and load_value; legal range 1..8.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 start_resume  input  1  request to start (from IDLE) or resume (from PAUSED) counting.
REQ-006 stop  input  1  request to pause counting.
REQ-007 clear  input  1  synchronous clear to zero and return to IDLE.
REQ-008 cin  input  1  count-enable tick, from a timebase or from the lower digit's cout.
REQ-009 dir  input  1  count direction: 0 = up, 1 = down.
REQ-010 load  input  1  synchronous load of load_value.
REQ-011 load_value  input  WIDTH  value for load.
REQ-012 number  output  WIDTH  current digit value, registered.
REQ-013 cout  output  1  carry (up) or borrow (down) to the next digit, combinational.
REQ-014 running  output  1  high while the state is RUN, registered.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and PAUSED.
REQ-016 Per-cycle priority SHALL be: clear > load > stop > start_resume > count.
REQ-017 clear=1 SHALL set number to 0 and the state to IDLE on the next edge, from any state.
REQ-018 load=1 SHALL set number to load_value on the next edge and leave the state unchanged; a value >= MODULUS SHALL saturate to MODULUS-1.
REQ-019 stop=1 in RUN SHALL move to PAUSED; stop in IDLE or PAUSED is a no-op.
REQ-020 start_resume=1 in IDLE or PAUSED SHALL move to RUN; in RUN it is a no-op.
REQ-021 When stop and start_resume are both 1, stop SHALL win.
REQ-022 number SHALL change by count only when state is RUN, cin=1, and clear, load and stop are all 0.
REQ-023 Up-count SHALL increment by 1 and wrap from MODULUS-1 to 0; down-count SHALL decrement by 1 and wrap from 0 to MODULUS-1.
REQ-024 cout SHALL be high in the same cycle that a count edge wraps (REQ-022 and REQ-023 conditions both met), so a chained digit advances on the same edge; otherwise cout SHALL be 0.
REQ-025 Counting SHALL start in the first cycle the registered state is RUN; the cycle carrying start_resume SHALL NOT count.
REQ-026 Changing dir SHALL take effect on the next count edge; no extra latency.
REQ-027 number SHALL never hold a value >= MODULUS.

Reset
REQ-028 While reset=0: number=0, state=IDLE, running=0; cout SHALL be 0 because state is not RUN.
REQ-029 Reset SHALL act immediately regardless of clk and SHALL override any operation in progress, including a load or a wrap.
REQ-030 After reset deasserts, the block SHALL stay in IDLE until start_resume=1.

Structure
REQ-031 The shared package stopwatch_pkg SHALL hold the state typedef (IDLE/RUN/PAUSED) and the direction constants DIR_UP=0 and DIR_DOWN=1.
REQ-032 Next-value and terminal-count logic SHALL be a combinational sub-module modn_step (inputs: value, dir; outputs: next value, at_terminal).
REQ-033 Illegal MODULUS or WIDTH values SHALL be rejected at elaboration.

Verification (MODULUS=6, WIDTH=4 unless stated)
REQ-034 Reset, start_resume pulse, cin=1 held, dir=0 -> number 0,1,2,3,4,5,0; cout=1 only in the cycle number=5.
REQ-035 dir=1 from number=0 in RUN, cin=1 -> number 5,4,...; cout=1 in the cycle number=0.
REQ-036 stop and start_resume both 1 in RUN at number=3 -> PAUSED, number holds 3; a later start_resume alone resumes at 3.
REQ-037 load=1 with load_value=9 -> number=5 and state unchanged; clear and load together -> number=0 and IDLE.
REQ-038 Two instances chained with MODULUS=10 and MODULUS=6, low cout driving high cin -> 59 rolls to 00 on a single edge; reset=0 pulsed mid-count between edges -> both digits read 0 immediately.
REQ-039 MODULUS=2, WIDTH=1, up-count -> number 0,1,0,1 and cout high in every cycle number=1.
